mm_array_ctrl: RTL and testbench

Sequencer for the N×N systolic multiply array built from `PE` tiles. On `start` it latches two N×N signed operand matrices, clears the array, and streams skewed rows of A and columns of B into the array edges. It then waits for the pipeline to drain, strobes result capture, and signals completion. It sits between the operand buffers and the array, and is the only driver of the array edge inputs and the array reset.

---
 rtl/mm_pkg.sv | 24 ++
 rtl/mm_skew_mux.sv | 36 +++
 rtl/mm_array_ctrl.sv | 106 ++++++++++
 tb/tb_mm_array_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared types and helpers for the systolic-array sequencer.
//   mm_state_e - sequencer states (idle, load, feed, drain, done)
//   mm_cnt_w   - beat-counter width, $clog2(2N)
//   mm_idx     - flat row-major element index (row*n + col)
package mm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFeed,
    StDrain,
    StDone
  } mm_state_e;

  // Beat counter must hold 0 .. 2N-2.
  function automatic int unsigned mm_cnt_w(input int unsigned n);
    return $clog2(2 * n);
  endfunction

  function automatic int mm_idx(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/mm_skew_mux.sv
// mm_skew_mux: combinational skew selector for the array edges.
//   t      in  beat index within FEED
//   a_mat  in  latched A, element A[i][k] at (i*N+k)*WIDTH
//   b_mat  in  latched B, element B[k][j] at (k*N+j)*WIDTH
//   a_edge out lane i = A[i][t-i] when 0 <= t-i < N, else 0
//   b_edge out lane j = B[t-j][j] when 0 <= t-j < N, else 0
module mm_skew_mux
  import mm_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CntW  = 3
) (
  input  logic [CntW-1:0]        t,
  input  logic [N*N*WIDTH-1:0]   a_mat,
  input  logic [N*N*WIDTH-1:0]   b_mat,
  output logic [N*WIDTH-1:0]     a_edge,
  output logic [N*WIDTH-1:0]     b_edge
);

  always_comb begin
    int d;
    d      = 0;
    a_edge = '0;
    b_edge = '0;
    for (int i = 0; i < int'(N); i++) begin
      // Row i (and column i) lags the array corner by i beats.
      d = int'(t) - i;
      if (d >= 0 && d < int'(N)) begin
        a_edge[i*WIDTH +: WIDTH] = a_mat[mm_idx(i, d, int'(N))*WIDTH +: WIDTH];
        b_edge[i*WIDTH +: WIDTH] = b_mat[mm_idx(d, i, int'(N))*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mm_array_ctrl.sv
// mm_array_ctrl: sequencer for an N x N systolic multiply array.
//   clk, rst_n   clock, async active-low reset
//   start        request a multiply (sampled only in idle)
//   a_mat, b_mat flat N*N signed operand matrices, latched on accept
//   a_edge       row-edge feed, lane i -> array row i
//   b_edge       column-edge feed, lane j -> array column j
//   array_rst    active-high PE reset (load cycle, and whenever rst_n=0)
//   capture      one-cycle strobe on the final drain cycle
//   busy         high from load through done
//   done         one-cycle completion pulse
module mm_array_ctrl
  import mm_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N*N*WIDTH-1:0]   a_mat,
  input  logic [N*N*WIDTH-1:0]   b_mat,
  output logic [N*WIDTH-1:0]     a_edge,
  output logic [N*WIDTH-1:0]     b_edge,
  output logic                   array_rst,
  output logic                   capture,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CntW = mm_cnt_w(N);
  localparam int unsigned DrnW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CntW-1:0] LastBeat  = CntW'(2 * N - 2);
  localparam logic [DrnW-1:0] LastDrain = DrnW'(DRAIN_CYC - 1);

  mm_state_e              state_q;
  logic [CntW-1:0]        t_q;
  logic [DrnW-1:0]        drn_q;
  logic [N*N*WIDTH-1:0]   a_q;
  logic [N*N*WIDTH-1:0]   b_q;
  logic [N*WIDTH-1:0]     a_mux;
  logic [N*WIDTH-1:0]     b_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      t_q     <= '0;
      drn_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a_mat;
            b_q     <= b_mat;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          t_q     <= '0;
          drn_q   <= '0;
          state_q <= StFeed;
        end
        StFeed: begin
          if (t_q == LastBeat) begin
            state_q <= StDrain;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        StDrain: begin
          if (drn_q == LastDrain) begin
            state_q <= StDone;
          end else begin
            drn_q <= drn_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  mm_skew_mux #(
    .N    (N),
    .WIDTH(WIDTH),
    .CntW (CntW)
  ) u_skew_mux (
    .t     (t_q),
    .a_mat (a_q),
    .b_mat (b_q),
    .a_edge(a_mux),
    .b_edge(b_mux)
  );

  // Outputs depend only on registered state/counters; rst_n overrides array_rst
  // so the PEs clear together with the controller.
  assign a_edge    = (state_q == StFeed) ? a_mux : '0;
  assign b_edge    = (state_q == StFeed) ? b_mux : '0;
  assign array_rst = ~rst_n | (state_q == StLoad);
  assign capture   = (state_q == StDrain) && (drn_q == LastDrain);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_mm_array_ctrl.sv
// tb_mm_array_ctrl: self-checking bench for mm_array_ctrl (N=4, WIDTH=8, DRAIN_CYC=4).
// The reference model tracks the run as a cycle number since the accepting edge and
// derives every output from that number; array sums are rebuilt from the observed edges.
module tb_mm_array_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam int RunLen  = 2 * N + D + 1;  // load .. done
  localparam int CapCyc  = 2 * N + D;
  localparam int NBeats  = 2 * N - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [N*N*W-1:0] a_mat = '0;
  logic [N*N*W-1:0] b_mat = '0;
  logic [N*W-1:0]   a_edge;
  logic [N*W-1:0]   b_edge;
  logic             array_rst;
  logic             capture;
  logic             busy;
  logic             done;

  mm_array_ctrl #(
    .N        (N),
    .WIDTH    (W),
    .DRAIN_CYC(D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_mat    (a_mat),
    .b_mat    (b_mat),
    .a_edge   (a_edge),
    .b_edge   (b_edge),
    .array_rst(array_rst),
    .capture  (capture),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [W-1:0] a_src [N][N];
  logic signed [W-1:0] b_src [N][N];
  logic signed [W-1:0] a_lat [N][N];
  logic signed [W-1:0] b_lat [N][N];
  logic signed [W-1:0] a_hist[NBeats][N];
  logic signed [W-1:0] b_hist[NBeats][N];
  int cyc = 0;  // 0 = idle, 1 = load, 2..2N = feed, .. RunLen = done

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < int'(N); i++)
      for (int k = 0; k < int'(N); k++) begin
        a_mat[(i*N+k)*W +: W] = a_src[i][k];
        b_mat[(i*N+k)*W +: W] = b_src[i][k];
      end
  endtask

  task automatic rand_inputs();
    logic [31:0] r;
    for (int i = 0; i < int'(N); i++)
      for (int k = 0; k < int'(N); k++) begin
        r = $urandom;
        a_src[i][k] = r[7:0];
        b_src[i][k] = r[15:8];
      end
    apply_inputs();
  endtask

  task automatic model_update();
    if (!rst_n) begin
      cyc = 0;
    end else if (cyc == 0) begin
      if (start) begin
        cyc   = 1;
        a_lat = a_src;
        b_lat = b_src;
        for (int t = 0; t < NBeats; t++)
          for (int i = 0; i < int'(N); i++) begin
            a_hist[t][i] = '0;
            b_hist[t][i] = '0;
          end
      end
    end else if (cyc == RunLen) begin
      cyc = 0;
    end else begin
      cyc++;
    end
  endtask

  task automatic check_sums();
    int sum;
    int ref_sum;
    int v;
    logic [15:0] s16;
    logic [15:0] r16;
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++) begin
        // PE(i,j) pairs row-i beat u with column-j beat u+j-i.
        sum = 0;
        for (int u = 0; u < NBeats; u++) begin
          v = u + j - i;
          if (v >= 0 && v < NBeats) sum += int'(a_hist[u][i]) * int'(b_hist[v][j]);
        end
        ref_sum = 0;
        for (int k = 0; k < int'(N); k++) ref_sum += int'(a_lat[i][k]) * int'(b_lat[k][j]);
        s16 = sum[15:0];
        r16 = ref_sum[15:0];
        check_eq($sformatf("sum_c%0d%0d", i, j), 64'(s16), 64'(r16));
      end
  endtask

  task automatic check_outputs();
    logic [N*W-1:0] ea;
    logic [N*W-1:0] eb;
    int t;
    ea = '0;
    eb = '0;
    if (cyc >= 2 && cyc <= 2 * int'(N)) begin
      t = cyc - 2;
      for (int i = 0; i < int'(N); i++) begin
        if (t - i >= 0 && t - i < int'(N)) begin
          ea[i*W +: W] = a_lat[i][t-i];
          eb[i*W +: W] = b_lat[t-i][i];
        end
        a_hist[t][i] = a_edge[i*W +: W];
        b_hist[t][i] = b_edge[i*W +: W];
      end
    end
    check_eq("a_edge", 64'(a_edge), 64'(ea));
    check_eq("b_edge", 64'(b_edge), 64'(eb));
    check_eq("busy", 64'(busy), 64'(cyc != 0));
    check_eq("array_rst", 64'(array_rst), 64'((cyc == 1) || !rst_n));
    check_eq("capture", 64'(capture), 64'(cyc == CapCyc));
    check_eq("done", 64'(done), 64'(cyc == RunLen));
    if (cyc == CapCyc && rst_n) check_sums();
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic finish_run();
    start = 1'b0;
    for (int n = 0; n < 2 * RunLen && cyc != 0; n++) step();
    check_eq("run_ends", 64'(cyc), 64'(0));
    step();
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < int'(N); i++)
      for (int k = 0; k < int'(N); k++) begin
        a_src[i][k] = '0;
        b_src[i][k] = '0;
      end
    apply_inputs();

    // Reset state
    #2 rst_n = 1'b0;
    #1 check_outputs();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Identity A, B[k][j] = 4k+j+1, with one start pulse
    for (int i = 0; i < int'(N); i++)
      for (int k = 0; k < int'(N); k++) begin
        a_src[i][k] = (i == k) ? 8'sd1 : 8'sd0;
        b_src[i][k] = 8'(i * 4 + k + 1);
      end
    apply_inputs();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("accept_cyc", 64'(cyc), 64'(1));
    finish_run();

    // Signed extremes: -128 everywhere, sums wrap to 0
    for (int i = 0; i < int'(N); i++)
      for (int k = 0; k < int'(N); k++) begin
        a_src[i][k] = 8'h80;
        b_src[i][k] = 8'h80;
      end
    apply_inputs();
    start = 1'b1;
    step();
    finish_run();

    // Start pulses in cycles 3 and 10 are ignored; A changes mid-feed
    rand_inputs();
    start = 1'b1;
    step();
    for (int n = 0; n < RunLen; n++) begin
      start = (cyc == 3 || cyc == 10);
      if (cyc == 4) rand_inputs();
      step();
    end
    start = 1'b0;
    repeat (3) step();

    // Random runs with random start pulses and operand churn
    for (int run = 0; run < 6; run++) begin
      rand_inputs();
      start = 1'b1;
      step();
      for (int n = 0; n < RunLen; n++) begin
        r = $urandom;
        start = (r[1:0] == 2'b00);
        if (r[2]) rand_inputs();
        step();
      end
      finish_run();
    end

    // Back-to-back: start held, operands change every cycle
    start = 1'b1;
    for (int n = 0; n < 3 * (RunLen + 1); n++) begin
      rand_inputs();
      step();
    end
    finish_run();

    // Reset mid-feed (cycle 5), then a fresh run
    rand_inputs();
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 5) step();
    #2 rst_n = 1'b0;
    #1;
    cyc = 0;
    check_outputs();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    rand_inputs();
    start = 1'b1;
    step();
    start = 1'b0;
    finish_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
